// File: rtl/memory_bus_bridge.sv
// Wishbone B4 classic single-transfer master for the multi-cycle core.
// Optional watchdog abort of stalled cycles is enabled by defining BUS_TIMEOUT_EN.
module memory_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic        abort,
  input  logic [31:0] read_address,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_sel,
  output logic [31:0] read_data,
  output logic        done,
  output logic        bus_error,
  output logic        busy,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i
);

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDone
  } state_t;

  state_t      r_state, w_state_d;
  logic        r_cyc, w_cyc_d;
  logic        r_we, w_we_d;
  logic        r_done, w_done_d;
  logic        r_bus_error, w_bus_error_d;
  logic        r_busy, w_busy_d;
  logic [31:0] r_adr, w_adr_d;
  logic [31:0] r_dat_o, w_dat_o_d;
  logic [3:0]  r_sel, w_sel_d;
  logic [31:0] r_read_data, w_read_data_d;

  logic w_launch;
  logic w_timeout;

  assign w_launch = (r_state == StIdle) && (memory_read || memory_write) && !abort;

`ifdef BUS_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] r_tmo_cnt, w_tmo_cnt_d;

  // Count value during the final allowed ACTIVE cycle.
  assign w_timeout = (r_state == StActive) &&
                     (r_tmo_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_tmo_cnt_d = r_tmo_cnt;
    if (w_launch) begin
      w_tmo_cnt_d = '0;
    end else if (r_state == StActive) begin
      w_tmo_cnt_d = r_tmo_cnt + TIMEOUT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt_d;
    end
  end
`else
  logic w_unused_params;
  assign w_timeout       = 1'b0;
  assign w_unused_params = ^{TIMEOUT_CYCLES, TIMEOUT_WIDTH};
`endif

  always_comb begin
    w_state_d     = r_state;
    w_cyc_d       = r_cyc;
    w_we_d        = r_we;
    w_done_d      = 1'b0;
    w_bus_error_d = r_bus_error;
    w_busy_d      = r_busy;
    w_adr_d       = r_adr;
    w_dat_o_d     = r_dat_o;
    w_sel_d       = r_sel;
    w_read_data_d = r_read_data;

    unique case (r_state)
      StIdle: begin
        if (w_launch) begin
          w_adr_d   = memory_write ? write_address : read_address;
          w_we_d    = memory_write;
          w_dat_o_d = write_data;
          w_sel_d   = memory_write ? write_sel : 4'b1111;
          w_cyc_d   = 1'b1;
          w_busy_d  = 1'b1;
          w_state_d = StActive;
        end
      end
      StActive: begin
        // err_i outranks ack_i; either outranks the watchdog.
        if (err_i || (!ack_i && w_timeout)) begin
          w_cyc_d       = 1'b0;
          w_done_d      = 1'b1;
          w_bus_error_d = 1'b1;
          w_state_d     = StDone;
        end else if (ack_i) begin
          if (!r_we) begin
            w_read_data_d = dat_i;
          end
          w_cyc_d       = 1'b0;
          w_done_d      = 1'b1;
          w_bus_error_d = 1'b0;
          w_state_d     = StDone;
        end
      end
      StDone: begin
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
      end
      default: begin
        w_cyc_d   = 1'b0;
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_done      <= 1'b0;
      r_bus_error <= 1'b0;
      r_busy      <= 1'b0;
      r_adr       <= '0;
      r_dat_o     <= '0;
      r_sel       <= 4'b0000;
      r_read_data <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cyc       <= w_cyc_d;
      r_we        <= w_we_d;
      r_done      <= w_done_d;
      r_bus_error <= w_bus_error_d;
      r_busy      <= w_busy_d;
      r_adr       <= w_adr_d;
      r_dat_o     <= w_dat_o_d;
      r_sel       <= w_sel_d;
      r_read_data <= w_read_data_d;
    end
  end

  // Strobe and cycle are identical for single non-pipelined transfers.
  assign cyc_o     = r_cyc;
  assign stb_o     = r_cyc;
  assign we_o      = r_we;
  assign adr_o     = r_adr;
  assign dat_o     = r_dat_o;
  assign sel_o     = r_sel;
  assign done      = r_done;
  assign bus_error = r_bus_error;
  assign busy      = r_busy;
  assign read_data = r_read_data;

endmodule

// File: tb/tb_memory_bus_bridge.sv
// Directed, table-driven bench for memory_bus_bridge plus hand-written corner sequences.
module tb_memory_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        memory_read, memory_write, abort;
  logic [31:0] read_address, write_address, write_data;
  logic [3:0]  write_sel;
  logic [31:0] read_data;
  logic        done, bus_error, busy;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i;
  logic        ack_i, err_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_bus_bridge #(
    .TIMEOUT_CYCLES(4),
    .TIMEOUT_WIDTH (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memory_read  (memory_read),
    .memory_write (memory_write),
    .abort        (abort),
    .read_address (read_address),
    .write_address(write_address),
    .write_data   (write_data),
    .write_sel    (write_sel),
    .read_data    (read_data),
    .done         (done),
    .bus_error    (bus_error),
    .busy         (busy),
    .cyc_o        (cyc_o),
    .stb_o        (stb_o),
    .we_o         (we_o),
    .adr_o        (adr_o),
    .dat_o        (dat_o),
    .sel_o        (sel_o),
    .dat_i        (dat_i),
    .ack_i        (ack_i),
    .err_i        (err_i)
  );

  // resp: 0 = ack, 1 = err, 2 = ack and err together
  typedef struct {
    logic        rd;
    logic        wr;
    logic        ab;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wsel;
    int          waits;
    int          resp;
    logic [31:0] sdat;
    logic        exp_launch;
    logic [31:0] exp_adr;
    logic        exp_we;
    logic [3:0]  exp_sel;
    logic        exp_berr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    memory_read  = 1'b0;
    memory_write = 1'b0;
    abort        = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    memory_read   = v.rd;
    memory_write  = v.wr;
    abort         = v.ab;
    read_address  = v.raddr;
    write_address = v.waddr;
    write_data    = v.wdata;
    write_sel     = v.wsel;
    step();
    clear_req();
    chk({tag, "_cyc"}, {31'd0, cyc_o}, {31'd0, v.exp_launch});
    if (v.exp_launch) begin
      chk({tag, "_stb"}, {31'd0, stb_o}, 32'd1);
      chk({tag, "_adr"}, adr_o, v.exp_adr);
      chk({tag, "_we"}, {31'd0, we_o}, {31'd0, v.exp_we});
      chk({tag, "_sel"}, {28'd0, sel_o}, {28'd0, v.exp_sel});
      chk({tag, "_dat_o"}, dat_o, v.wdata);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      for (int w = 0; w < v.waits; w++) begin
        step();
        chk({tag, "_wait_cyc"}, {31'd0, cyc_o}, 32'd1);
        chk({tag, "_wait_adr"}, adr_o, v.exp_adr);
        chk({tag, "_wait_sel"}, {28'd0, sel_o}, {28'd0, v.exp_sel});
        chk({tag, "_wait_dat_o"}, dat_o, v.wdata);
        chk({tag, "_wait_done"}, {31'd0, done}, 32'd0);
      end
      ack_i = (v.resp != 1);
      err_i = (v.resp != 0);
      dat_i = v.sdat;
      step();
      ack_i = 1'b0;
      err_i = 1'b0;
      dat_i = 32'hFFFF_FFFF;
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_berr"}, {31'd0, bus_error}, {31'd0, v.exp_berr});
      chk({tag, "_cyc_end"}, {31'd0, cyc_o}, 32'd0);
      chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
      step();
      chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      chk({tag, "_berr_hold"}, {31'd0, bus_error}, {31'd0, v.exp_berr});
      chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
      chk({tag, "_rdata"}, read_data, v.exp_rdata);
    end else begin
      step();
      chk({tag, "_nolaunch_cyc"}, {31'd0, cyc_o}, 32'd0);
      chk({tag, "_nolaunch_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_rdata"}, read_data, v.exp_rdata);
    end
  endtask

  initial begin
    logic stuck_ok;
    //         rd    wr    ab    raddr         waddr         wdata         wsel     w  r  sdat
    //         launch adr          we    sel      berr  rdata
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_9000, 32'h0000_0000, 4'h3, 0, 0,
                32'hDEAD_BEEF, 1'b1, 32'h0000_0100, 1'b0, 4'hF, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0700, 32'h0000_2004, 32'h0000_AB00, 4'b0010, 3, 0,
                32'h1234_5678, 1'b1, 32'h0000_2004, 1'b1, 4'b0010, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0400, 32'h0000_55AA, 4'b1100, 1, 0,
                32'h8765_4321, 1'b1, 32'h0000_0400, 1'b1, 4'b1100, 1'b0, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h0000_0600, 32'h0000_0000, 32'h0000_0000, 4'h0, 0, 0,
                32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0500, 32'h0000_0000, 32'h0000_0000, 4'h0, 1, 1,
                32'h0000_0BAD, 1'b1, 32'h0000_0500, 1'b0, 4'hF, 1'b1, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0504, 32'h0000_0000, 32'h0000_0000, 4'h0, 0, 0,
                32'hCAFE_F00D, 1'b1, 32'h0000_0504, 1'b0, 4'hF, 1'b0, 32'hCAFE_F00D};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0000_0508, 32'h0000_0000, 32'h0000_0000, 4'h0, 0, 2,
                32'h1111_1111, 1'b1, 32'h0000_0508, 1'b0, 4'hF, 1'b1, 32'hCAFE_F00D};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h0000_050C, 32'h0000_0000, 32'h0000_0000, 4'h0, 2, 0,
                32'h0BAD_C0DE, 1'b1, 32'h0000_050C, 1'b0, 4'hF, 1'b0, 32'h0BAD_C0DE};

    reset = 1'b1;
    clear_req();
    read_address  = '0;
    write_address = '0;
    write_data    = '0;
    write_sel     = '0;
    dat_i         = '0;
    ack_i         = 1'b0;
    err_i         = 1'b0;
    step();
    step();
    chk("rst_cyc", {31'd0, cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, stb_o}, 32'd0);
    chk("rst_we", {31'd0, we_o}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_berr", {31'd0, bus_error}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_adr", adr_o, 32'd0);
    chk("rst_dat_o", dat_o, 32'd0);
    chk("rst_sel", {28'd0, sel_o}, 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i]);
    end

    // Requests during ACTIVE and DONE are dropped, not queued.
    memory_read  = 1'b1;
    read_address = 32'h0000_0A00;
    step();
    clear_req();
    memory_write  = 1'b1;
    write_address = 32'h0000_0B00;
    step();
    chk("busy_adr_hold", adr_o, 32'h0000_0A00);
    chk("busy_we_hold", {31'd0, we_o}, 32'd0);
    clear_req();
    ack_i = 1'b1;
    dat_i = 32'hA5A5_5A5A;
    step();
    ack_i = 1'b0;
    chk("busy_done", {31'd0, done}, 32'd1);
    memory_write = 1'b1;
    step();
    clear_req();
    chk("done_req_ignored", {31'd0, cyc_o}, 32'd0);
    step();
    chk("done_req_not_queued", {31'd0, cyc_o}, 32'd0);
    chk("busy_rdata", read_data, 32'hA5A5_5A5A);

    // Reset while ACTIVE clears everything without a done pulse.
    memory_read  = 1'b1;
    read_address = 32'h0000_0C00;
    step();
    clear_req();
    chk("mid_rst_active", {31'd0, cyc_o}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_cyc", {31'd0, cyc_o}, 32'd0);
    chk("mid_rst_stb", {31'd0, stb_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_rdata", read_data, 32'd0);
    step();
    chk("mid_rst_no_done", {31'd0, done}, 32'd0);
    chk("mid_rst_idle", {31'd0, cyc_o}, 32'd0);

    // Unresponsive slave.
    memory_read  = 1'b1;
    read_address = 32'h0000_0D00;
    step();
    clear_req();
    chk("stall_launch", {31'd0, cyc_o}, 32'd1);
`ifdef BUS_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      step();
      chk("tmo_still_active", {31'd0, cyc_o}, 32'd1);
    end
    step();
    chk("tmo_done", {31'd0, done}, 32'd1);
    chk("tmo_berr", {31'd0, bus_error}, 32'd1);
    chk("tmo_cyc", {31'd0, cyc_o}, 32'd0);
    step();
`else
    stuck_ok = 1'b1;
    for (int k = 0; k < 120; k++) begin
      step();
      if (cyc_o !== 1'b1 || done !== 1'b0) stuck_ok = 1'b0;
    end
    chk("no_tmo_cyc_held", {31'd0, stuck_ok}, 32'd1);
    ack_i = 1'b1;
    dat_i = 32'h0F0F_0F0F;
    step();
    ack_i = 1'b0;
    chk("no_tmo_done", {31'd0, done}, 32'd1);
    chk("no_tmo_berr", {31'd0, bus_error}, 32'd0);
    step();
    chk("no_tmo_rdata", read_data, 32'h0F0F_0F0F);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_bus_bridge.md
Name: memory_bus_bridge

Overview:
- Wishbone classic (B4, non-pipelined) single-transfer master between the multi-cycle core and the shared instruction/data bus.
- Accepts one read or write request from the controller and data path, runs one bus cycle, and returns read data plus a one-cycle completion pulse.
- The controller holds its FSM in the memory state until `done` is seen.
- Read data feeds the instruction register and the load decoder.

Parameters:
- TIMEOUT_CYCLES, 255: number of ACTIVE cycles without ack_i or err_i before the cycle is aborted. Only used under BUS_TIMEOUT_EN.
- TIMEOUT_WIDTH, 8: width of the watchdog counter. Must satisfy 2^TIMEOUT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- memory_read  in  1  read request, sampled in IDLE
- memory_write  in  1  write request, sampled in IDLE; has priority over memory_read
- abort  in  1  suppress launch in the same cycle (misaligned exception)
- read_address  in  32  address used for reads
- write_address  in  32  address used for writes
- write_data  in  32  store data, already lane-aligned
- write_sel  in  4  byte enables for writes
- read_data  out  32  captured dat_i of the last successful read
- done  out  1  one-cycle pulse when a transfer finishes (ack, err or timeout)
- bus_error  out  1  valid with done: transfer ended by err_i or timeout
- busy  out  1  high in ACTIVE and DONE
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe
- we_o  out  1  Wishbone write enable
- adr_o  out  32  Wishbone address
- dat_o  out  32  Wishbone write data
- sel_o  out  4  Wishbone byte select
- dat_i  in  32  Wishbone read data
- ack_i  in  1  Wishbone acknowledge
- err_i  in  1  Wishbone error

Behaviour:
- Reset values:
  - State IDLE.
  - cyc_o, stb_o, we_o, done, bus_error, busy all 0.
  - adr_o, dat_o, read_data all 0.
  - sel_o = 4'b0000.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, ACTIVE, DONE.
- IDLE:
  - If (memory_read | memory_write) & !abort, on the edge:
    - adr_o <= write ? write_address : read_address.
    - we_o <= memory_write.
    - dat_o <= write_data.
    - sel_o <= write ? write_sel : 4'b1111.
    - cyc_o <= 1, stb_o <= 1; go to ACTIVE.
  - Otherwise stay in IDLE; no bus activity.
- ACTIVE (cyc_o = stb_o = 1; adr_o, dat_o, sel_o, we_o held stable):
  - ack_i: if !we_o, read_data <= dat_i. Then cyc_o <= 0, stb_o <= 0, done <= 1, bus_error <= 0; go to DONE.
  - err_i (ack_i low): same exit without capturing data; bus_error <= 1.
  - ack_i and err_i together: treated as err_i; read_data unchanged.
  - Neither: stay in ACTIVE.
- DONE:
  - done is high for exactly this one cycle; go to IDLE.
  - done <= 0. bus_error holds its value until the next done.
  - Requests in this cycle are ignored. The controller must re-assert the request in IDLE.
- Latency: request at edge N gives cyc_o high in cycle N+1. Ack sampled at edge M gives done high in cycle M+1. Zero-wait-state slave: request to done = 2 cycles, minimum 3 cycles between launches.
- Requests arriving while busy are ignored, not queued.
- read_data holds its last value across writes, errors and idle cycles.
- Reset in ACTIVE: cyc_o and stb_o drop at that edge; no done is generated.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_WIDTH counter clears on entry to ACTIVE and increments each ACTIVE cycle.
  - When the count reaches TIMEOUT_CYCLES with no ack_i or err_i, exit exactly as for err_i (bus_error = 1).
  - ack_i or err_i in the same cycle as the timeout wins.
- Undefined: no counter is instantiated; ACTIVE waits indefinitely; TIMEOUT_* parameters are unused.

Test Plan:
- Read, zero wait: read_address=0x0000_0100, memory_read=1; slave acks in the first ACTIVE cycle with dat_i=0xDEAD_BEEF -> adr_o=0x100, sel_o=4'hF, we_o=0; done at request+2; read_data=0xDEADBEEF; bus_error=0.
- Write, 3 wait states: write_address=0x2004, write_data=0x0000_AB00, write_sel=4'b0010 -> cyc_o high for 4 cycles with adr_o, dat_o, sel_o stable; done one cycle after ack; read_data unchanged.
- Simultaneous inputs:
  - memory_read=memory_write=1 -> write issued to write_address.
  - abort=1 with memory_read=1 -> cyc_o stays 0, no done.
- Error: err_i in the second ACTIVE cycle -> done=1 with bus_error=1, read_data unchanged. A following good read clears bus_error to 0 at its done.
- Reset mid-cycle: reset asserted in ACTIVE -> next cycle cyc_o=stb_o=0, state IDLE, no done pulse, read_data=0.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4): slave never responds -> done with bus_error=1 after the fourth ACTIVE cycle. Without the macro, cyc_o remains high for 100+ cycles.
